// File: rtl/ysyx_22050550_id_ctrl_pkg.sv
// Shared opcode constants and source-operand helpers for the decode-stage controller.
// Carries the R_type / I_type32 / R_type32 opcodes and the register-address width alongside the base set.
package ysyx_22050550_id_ctrl_pkg;

  localparam int REG_ADDR_W = 5;  // ysyx_22050550_RegAddrBus is [REG_ADDR_W-1:0]

  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE32 = 7'b0011011;
  localparam logic [6:0] OP_R_TYPE32 = 7'b0111011;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
  } src_use_t;

  function automatic src_use_t src_use(input logic [31:0] instr);
    src_use_t u;
    u = '{use_rs1: 1'b0, use_rs2: 1'b0};
    case (instr[6:0])
      OP_JALR, OP_LOAD, OP_I_TYPE, OP_I_TYPE32: u = '{use_rs1: 1'b1, use_rs2: 1'b0};
      OP_B_TYPE, OP_STORE, OP_R_TYPE, OP_R_TYPE32: u = '{use_rs1: 1'b1, use_rs2: 1'b1};
      default: u = '{use_rs1: 1'b0, use_rs2: 1'b0};
    endcase
    return u;
  endfunction

  function automatic logic [REG_ADDR_W-1:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/ysyx_22050550_hazard_det.sv
// Load-use hazard detector: compares the decode instruction's used sources against the EX load's rd.
// Purely combinational; the parent qualifies the result with slot validity.
module ysyx_22050550_hazard_det
  import ysyx_22050550_id_ctrl_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0]     instr,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard_raw
);

  src_use_t              use_s;
  logic [REG_ADDR_W-1:0] rs1_s;
  logic [REG_ADDR_W-1:0] rs2_s;
  logic                  match_s;

  // source decode and rd comparison; x0 is never a real producer
  always_comb begin
    use_s      = src_use(instr);
    rs1_s      = rs1_of(instr);
    rs2_s      = rs2_of(instr);
    match_s    = (use_s.use_rs1 & (rs1_s == ex_rd)) | (use_s.use_rs2 & (rs2_s == ex_rd));
    hazard_raw = ex_valid & ex_is_load & (ex_rd != {REG_ADDR_W{1'b0}}) & match_s;
  end

endmodule

// File: rtl/ysyx_22050550_id_ctrl.sv
// Decode-stage controller: IF->ID pipeline register with valid/ready handshakes,
// load-use stall, redirect flush and a saturating stall counter.
module ysyx_22050550_id_ctrl
  import ysyx_22050550_id_ctrl_pkg::*;
#(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [PC_W-1:0]       if_pc,
  input  logic [INST_W-1:0]     if_instr,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [PC_W-1:0]       id_pc,
  output logic [INST_W-1:0]     id_instr,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic              slot_v_q, slot_v_d;
  logic [PC_W-1:0]   slot_pc_q, slot_pc_d;
  logic [INST_W-1:0] slot_instr_q, slot_instr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hazard_raw_s;
  logic hazard_s;
  logic fire_out_s;

  ysyx_22050550_hazard_det #(
    .INST_W(INST_W)
  ) u_hazard_det (
    .instr     (slot_instr_q),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_rd     (ex_rd),
    .hazard_raw(hazard_raw_s)
  );

  // handshake outputs; if_ready deliberately never depends on if_valid
  always_comb begin
    hazard_s   = slot_v_q & hazard_raw_s;
    id_valid   = slot_v_q & ~hazard_s & ~flush;
    fire_out_s = id_valid & id_ready;
    if_ready   = flush | ~slot_v_q | fire_out_s;
  end

  // slot next state: a flushed beat is accepted but dropped as wrong-path
  always_comb begin
    slot_v_d     = slot_v_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    if (flush) begin
      slot_v_d = 1'b0;
    end else if (if_valid & if_ready) begin
      slot_v_d     = 1'b1;
      slot_pc_d    = if_pc;
      slot_instr_d = if_instr;
    end else if (fire_out_s) begin
      slot_v_d = 1'b0;
    end else begin
      slot_v_d = slot_v_q;
    end
  end

  // stall counter saturates at all-ones; flush overrides a concurrent hazard
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_s & ~flush & (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q     <= 1'b0;
      slot_pc_q    <= {PC_W{1'b0}};
      slot_instr_q <= {INST_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      slot_v_q     <= slot_v_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign id_pc     = slot_pc_q;
  assign id_instr  = slot_instr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22050550_id_ctrl.sv
// Self-checking bench for ysyx_22050550_id_ctrl: directed scenarios plus randomized traffic
// against a slot-level reference model; CNT_W=4 so counter saturation is reachable.
module tb_ysyx_22050550_id_ctrl;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_valid = 1'b0;
  logic              if_ready;
  logic [PC_W-1:0]   if_pc = 64'h0;
  logic [INST_W-1:0] if_instr = 32'h0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_instr;
  logic              ex_valid = 1'b0;
  logic              ex_is_load = 1'b0;
  logic [4:0]        ex_rd = 5'd0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  bit              m_v = 1'b0;
  logic [PC_W-1:0] m_pc = 64'h0;
  logic [31:0]     m_instr = 32'h0;
  int              m_cnt = 0;

  localparam logic [31:0] ADDI_X1  = 32'h00500093;
  localparam logic [31:0] ADDI_X2  = 32'h00a00113;
  localparam logic [31:0] ADD_X3   = 32'h002081B3;
  localparam logic [31:0] LUI_X1   = 32'h000010B7;

  ysyx_22050550_id_ctrl #(
    .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit uses_rs1(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return op inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b1100011,
                      7'b0100011, 7'b0110011, 7'b0011011, 7'b0111011};
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return op inside {7'b1100011, 7'b0100011, 7'b0110011, 7'b0111011};
  endfunction

  function automatic bit m_hazard();
    bit dep;
    dep = (uses_rs1(m_instr) && (m_instr[19:15] == ex_rd)) ||
          (uses_rs2(m_instr) && (m_instr[24:20] == ex_rd));
    return m_v && ex_valid && ex_is_load && (ex_rd != 5'd0) && dep;
  endfunction

  function automatic bit m_id_valid();
    return m_v && !m_hazard() && !flush;
  endfunction

  function automatic bit m_if_ready();
    return flush || !m_v || (m_id_valid() && id_ready);
  endfunction

  // apply one clock edge to the model using the inputs currently driven
  task automatic advance();
    bit              nv;
    logic [PC_W-1:0] npc;
    logic [31:0]     ni;
    int              nc;
    nv = m_v; npc = m_pc; ni = m_instr; nc = m_cnt;
    if (rst) begin
      nv = 1'b0; npc = 64'h0; ni = 32'h0; nc = 0;
    end else begin
      if (m_hazard() && !flush && m_cnt < CNT_MAX) nc = m_cnt + 1;
      if (flush) nv = 1'b0;
      else if (if_valid && m_if_ready()) begin
        nv = 1'b1; npc = if_pc; ni = if_instr;
      end else if (m_id_valid() && id_ready) nv = 1'b0;
    end
    @(posedge clk);
    m_v = nv; m_pc = npc; m_instr = ni; m_cnt = nc;
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; id_ready = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    ex_rd = 5'd0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    advance();
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %0b exp 0", id_valid); else n_pass++;
    n_total++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready got %0b exp 1", if_ready); else n_pass++;
    n_total++; if (id_pc !== 64'h0) $display("FAIL reset_id_pc got %h exp 0", id_pc); else n_pass++;
    n_total++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got %h exp 0", id_instr); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] pc;
    do_reset();
    pc = 64'h80000000;
    if_valid = 1'b1; id_ready = 1'b1; if_pc = pc; if_instr = ADDI_X1;
    #1;
    n_total++; if (if_ready !== 1'b1) $display("FAIL stream_first_ready got %0b exp 1", if_ready); else n_pass++;
    advance();
    for (int k = 0; k < 4; k++) begin
      if_pc = pc + 64'd4; if_instr = (k % 2 == 0) ? ADDI_X2 : ADDI_X1;
      #1;
      n_total++; if (id_valid !== 1'b1) $display("FAIL stream_id_valid[%0d] got %0b exp 1", k, id_valid); else n_pass++;
      n_total++; if (id_pc !== pc) $display("FAIL stream_id_pc[%0d] got %h exp %h", k, id_pc, pc); else n_pass++;
      n_total++; if (if_ready !== 1'b1) $display("FAIL stream_if_ready[%0d] got %0b exp 1", k, if_ready); else n_pass++;
      pc = pc + 64'd4;
      advance();
    end
    if_valid = 1'b0;
    advance();
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL stream_drain got %0b exp 0", id_valid); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    if_valid = 1'b1; id_ready = 1'b1; if_pc = 64'h100; if_instr = ADD_X3;
    advance();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL load_use_id_valid got %0b exp 0", id_valid); else n_pass++;
    n_total++; if (if_ready !== 1'b0) $display("FAIL load_use_if_ready got %0b exp 0", if_ready); else n_pass++;
    advance();
    ex_is_load = 1'b0;
    #1;
    n_total++; if (stall_cnt !== 4'd1) $display("FAIL load_use_cnt got %0d exp 1", stall_cnt); else n_pass++;
    n_total++; if (id_valid !== 1'b1) $display("FAIL load_use_release got %0b exp 1", id_valid); else n_pass++;
    n_total++; if (id_pc !== 64'h100) $display("FAIL load_use_pc got %h exp 100", id_pc); else n_pass++;
    advance();
    idle_inputs();
  endtask

  task automatic test_no_false_stall();
    do_reset();
    if_valid = 1'b1; id_ready = 1'b1; if_pc = 64'h180; if_instr = LUI_X1;
    advance();
    if_valid = 1'b0; id_ready = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    #1;
    n_total++; if (id_valid !== 1'b1) $display("FAIL nofalse_lui got %0b exp 1", id_valid); else n_pass++;
    id_ready = 1'b1; if_valid = 1'b1; if_pc = 64'h184; if_instr = ADD_X3;
    advance();
    if_valid = 1'b0; ex_rd = 5'd0;
    #1;
    n_total++; if (id_valid !== 1'b1) $display("FAIL nofalse_rd0 got %0b exp 1", id_valid); else n_pass++;
    n_total++; if (id_instr !== ADD_X3) $display("FAIL nofalse_instr got %h exp %h", id_instr, ADD_X3); else n_pass++;
    advance();
    #1;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL nofalse_cnt got %0d exp 0", stall_cnt); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    if_valid = 1'b1; id_ready = 1'b1; if_pc = 64'h200; if_instr = ADDI_X1;
    advance();
    id_ready = 1'b0; if_pc = 64'h204; if_instr = ADDI_X2;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (if_ready !== 1'b0) $display("FAIL bp_if_ready[%0d] got %0b exp 0", k, if_ready); else n_pass++;
      n_total++; if (id_pc !== 64'h200) $display("FAIL bp_pc[%0d] got %h exp 200", k, id_pc); else n_pass++;
      n_total++; if (id_instr !== ADDI_X1) $display("FAIL bp_instr[%0d] got %h exp %h", k, id_instr, ADDI_X1); else n_pass++;
      advance();
    end
    id_ready = 1'b1;
    #1;
    n_total++; if (if_ready !== 1'b1) $display("FAIL bp_release_ready got %0b exp 1", if_ready); else n_pass++;
    advance();
    if_valid = 1'b0;
    #1;
    n_total++; if (id_pc !== 64'h204) $display("FAIL bp_new_pc got %h exp 204", id_pc); else n_pass++;
    n_total++; if (id_instr !== ADDI_X2) $display("FAIL bp_new_instr got %h exp %h", id_instr, ADDI_X2); else n_pass++;
    advance();
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    if_valid = 1'b1; id_ready = 1'b1; if_pc = 64'h300; if_instr = ADDI_X1;
    advance();
    flush = 1'b1; if_pc = 64'h304; if_instr = ADDI_X2;
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL flush_id_valid got %0b exp 0", id_valid); else n_pass++;
    n_total++; if (if_ready !== 1'b1) $display("FAIL flush_if_ready got %0b exp 1", if_ready); else n_pass++;
    advance();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL flush_after_valid got %0b exp 0", id_valid); else n_pass++;
    n_total++; if (if_ready !== 1'b1) $display("FAIL flush_after_ready got %0b exp 1", if_ready); else n_pass++;
    n_total++; if (id_pc !== 64'h300) $display("FAIL flush_pc_hold got %h exp 300", id_pc); else n_pass++;
    // flush concurrent with a hazard must not count
    if_valid = 1'b1; if_pc = 64'h308; if_instr = ADD_X3;
    advance();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2; flush = 1'b1;
    advance();
    idle_inputs();
    #1;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL flush_hazard_cnt got %0d exp 0", stall_cnt); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL flush_hazard_valid got %0b exp 0", id_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    if_valid = 1'b1; id_ready = 1'b1; if_pc = 64'h400; if_instr = ADD_X3;
    advance();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2;
    for (int k = 0; k < 20; k++) advance();
    #1;
    n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_cnt got %0d exp 15", stall_cnt); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL sat_id_valid got %0b exp 0", id_valid); else n_pass++;
    rst = 1'b1;
    advance();
    rst = 1'b0;
    #1;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_stall_valid got %0b exp 0", id_valid); else n_pass++;
    n_total++; if (if_ready !== 1'b1) $display("FAIL rst_stall_ready got %0b exp 1", if_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'b1100111, 7'b0000011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100011, 7'b0100011, 7'b0110011, 7'b0011011, 7'b0111011, 7'b1111111};
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      rst        = ($urandom_range(0, 60) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      if_valid   = ($urandom_range(0, 3) != 0);
      id_ready   = ($urandom_range(0, 3) != 0);
      ex_valid   = ($urandom_range(0, 1) == 1);
      ex_is_load = ($urandom_range(0, 1) == 1);
      ex_rd      = 5'($urandom_range(0, 3));
      if_pc      = {32'h8000_0000, $urandom} & ~64'h3;
      if_instr   = {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:7],
                    ops[$urandom_range(0, 11)]};
      #1;
      n_total++; if (id_valid !== m_id_valid()) $display("FAIL rand_id_valid[%0d] got %0b exp %0b", k, id_valid, m_id_valid()); else n_pass++;
      n_total++; if (if_ready !== m_if_ready()) $display("FAIL rand_if_ready[%0d] got %0b exp %0b", k, if_ready, m_if_ready()); else n_pass++;
      n_total++; if (id_pc !== m_pc) $display("FAIL rand_id_pc[%0d] got %h exp %h", k, id_pc, m_pc); else n_pass++;
      n_total++; if (id_instr !== m_instr) $display("FAIL rand_id_instr[%0d] got %h exp %h", k, id_instr, m_instr); else n_pass++;
      n_total++; if (int'(stall_cnt) !== m_cnt) $display("FAIL rand_stall_cnt[%0d] got %0d exp %0d", k, stall_cnt, m_cnt); else n_pass++;
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_false_stall();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
